// File: rtl/kanagawa_hal_reset_sequencer.sv
// kanagawa_hal_reset_sequencer
//   Generates the synchronous core reset for one clock domain and completes
//   the reset handshake with the logic it drives. The board-level asynchronous
//   reset is synchronised, stretched for HOLD_CYCLES cycles, and the block then
//   waits for the downstream domain to acknowledge initialisation.
//
// Parameters
//   HOLD_CYCLES  cycles rst stays high after internal reset release (>=1)
//   ACK_TIMEOUT  max cycles waiting for rst_ack (timeout build only, >=1)
//
// Ports
//   clk           clock
//   arst          asynchronous active-high reset
//   soft_rst_req  synchronous single-cycle request to restart the sequence
//   rst_ack       downstream init done (asynchronous level)
//   rst           synchronous active-high reset to the downstream domain
//   rst_done      high while in RUN
//   ack_timeout   sticky: RUN was entered through the ack timeout
//   state         debug state view: 0=HOLD, 1=WAIT_ACK, 2=RUN
//
// Build option
//   KANAGAWA_HAL_RESET_SEQ_TIMEOUT_EN  enables the WAIT_ACK timeout; without
//   it WAIT_ACK waits indefinitely and ack_timeout is tied to 0.

module kanagawa_hal_reset_sequencer #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT = 256
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       soft_rst_req,
  input  logic       rst_ack,
  output logic       rst,
  output logic       rst_done,
  output logic       ack_timeout,
  output logic [1:0] state
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
`ifdef KANAGAWA_HAL_RESET_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_RUN      = 2'd2
  } state_e;

  // Reset synchroniser: asserts asynchronously, releases after two edges.
  logic [1:0] arst_sync_q, arst_sync_d;
  logic       rst_int;

  // rst_ack synchroniser.
  logic [1:0] ack_sync_q, ack_sync_d;
  logic       ack_s;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ack_to_q, ack_to_d;

  always_comb begin
    arst_sync_d = {arst_sync_q[0], 1'b0};
    ack_sync_d  = {ack_sync_q[0], rst_ack};
  end

  assign rst_int = arst_sync_q[1];
  assign ack_s   = ack_sync_q[1];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      arst_sync_q <= '1;
      ack_sync_q  <= '0;
    end else begin
      arst_sync_q <= arst_sync_d;
      ack_sync_q  <= ack_sync_d;
    end
  end

  // State is reset asynchronously by arst (so rst rises without a clock) and
  // held synchronously in HOLD until the synchronised reset releases.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= ST_HOLD;
      cnt_q    <= '0;
      ack_to_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_to_q <= ack_to_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_to_d = ack_to_q;
    if (rst_int || soft_rst_req) begin
      // Soft request outranks every other transition, including HOLD exit.
      state_d  = ST_HOLD;
      cnt_d    = '0;
      ack_to_d = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_WAIT_ACK;
            cnt_d   = '0;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_WAIT_ACK: begin
          if (ack_s) begin
            state_d = ST_RUN;
          end
`ifdef KANAGAWA_HAL_RESET_SEQ_TIMEOUT_EN
          // Ack wins over a timeout reached in the same cycle.
          else if (cnt_q == ACK_LAST) begin
            state_d  = ST_RUN;
            ack_to_d = 1'b1;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CW'(1);
          end
`endif
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign rst      = (state_q == ST_HOLD);
  assign rst_done = (state_q == ST_RUN);
  assign state    = state_q;

`ifdef KANAGAWA_HAL_RESET_SEQ_TIMEOUT_EN
  assign ack_timeout = ack_to_q;
`else
  assign ack_timeout = 1'b0;
`endif

endmodule
